// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush sequencer: arbitrates load-use stalls, multi-cycle EX holds and redirects.
// Optional STALL_PERF_CNT_EN adds a saturating count of cycles in which ID is held.
module pipe_stall_ctrl #(
  parameter int unsigned MC_LEN_W = 6,
  parameter int unsigned PC_W     = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stallreq_id,
  input  logic                mc_start,
  input  logic [MC_LEN_W-1:0] mc_len,
  input  logic                flush_req,
  input  logic [PC_W-1:0]     flush_pc,
`ifdef STALL_PERF_CNT_EN
  input  logic                perf_clr,
  output logic [31:0]         stall_cycles,
`endif
  output logic [5:0]          stall,
  output logic                mc_done,
  output logic                mc_abort,
  output logic                flush,
  output logic [PC_W-1:0]     new_pc,
  output logic                busy
);

  localparam logic [5:0] StallNone = 6'b000000;
  localparam logic [5:0] StallId   = 6'b000111;
  localparam logic [5:0] StallEx   = 6'b001111;
  localparam logic [5:0] StallAll  = 6'b111111;

  typedef enum logic [1:0] {StRun, StMcycle, StFlush} state_e;

  state_e              state_q, state_d;
  logic [MC_LEN_W-1:0] cnt_q, cnt_d;
  logic [PC_W-1:0]     pend_pc_q, pend_pc_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_pc_d = pend_pc_q;
    stall     = StallNone;
    mc_done   = 1'b0;
    mc_abort  = 1'b0;
    unique case (state_q)
      StRun: begin
        if (flush_req) begin
          stall     = StallAll;
          pend_pc_d = flush_pc;
          state_d   = StFlush;
        end else if (mc_start) begin
          if (mc_len == '0) begin
            mc_done = 1'b1;
          end else begin
            stall   = StallEx;
            cnt_d   = mc_len - MC_LEN_W'(1);
            state_d = StMcycle;
          end
        end else if (stallreq_id) begin
          stall = StallId;
        end
      end
      StMcycle: begin
        if (flush_req) begin
          stall     = StallAll;
          mc_abort  = 1'b1;
          pend_pc_d = flush_pc;
          state_d   = StFlush;
        end else if (cnt_q != '0) begin
          stall = StallEx;
          cnt_d = cnt_q - MC_LEN_W'(1);
        end else begin
          mc_done = 1'b1;
          stall   = stallreq_id ? StallId : StallNone;
          state_d = StRun;
        end
      end
      StFlush: begin
        if (flush_req) begin
          pend_pc_d = flush_pc;
        end else begin
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
    // Reset cycle must not leak strobes for an operation it is cancelling.
    if (rst) begin
      stall    = StallNone;
      mc_done  = 1'b0;
      mc_abort = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StRun;
      cnt_q     <= '0;
      pend_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  always_comb begin
    flush  = (state_q == StFlush) && !rst;
    new_pc = flush ? pend_pc_q : '0;
    busy   = (state_q != StRun) && !rst;
  end

`ifdef STALL_PERF_CNT_EN
  logic [31:0] stall_cycles_q;

  always_ff @(posedge clk) begin
    if (rst || perf_clr) begin
      stall_cycles_q <= '0;
    end else if (stall[2] && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_q <= stall_cycles_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Table-driven check of pipe_stall_ctrl: one record per cycle, plus a perf-counter sequence.
module tb_pipe_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst, stallreq_id, mc_start, flush_req;
  logic [5:0]  mc_len;
  logic [31:0] flush_pc;
  logic [5:0]  stall;
  logic        mc_done, mc_abort, flush, busy;
  logic [31:0] new_pc;
`ifdef STALL_PERF_CNT_EN
  logic        perf_clr;
  logic [31:0] stall_cycles;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.MC_LEN_W(6), .PC_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .stallreq_id (stallreq_id),
    .mc_start    (mc_start),
    .mc_len      (mc_len),
    .flush_req   (flush_req),
    .flush_pc    (flush_pc),
`ifdef STALL_PERF_CNT_EN
    .perf_clr    (perf_clr),
    .stall_cycles(stall_cycles),
`endif
    .stall       (stall),
    .mc_done     (mc_done),
    .mc_abort    (mc_abort),
    .flush       (flush),
    .new_pc      (new_pc),
    .busy        (busy)
  );

  typedef struct {
    logic        rst;
    logic        sid;
    logic        mcs;
    logic [5:0]  len;
    logic        fr;
    logic [31:0] fpc;
    logic [5:0]  es;
    logic        ed;
    logic        ea;
    logic        ef;
    logic [31:0] enp;
    logic        eb;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic sid, input logic mcs, input logic [5:0] len,
                     input logic fr, input logic [31:0] fpc, input logic [5:0] es,
                     input logic ed, input logic ea, input logic ef, input logic [31:0] enp,
                     input logic eb);
    vec_t v;
    v.rst = r; v.sid = sid; v.mcs = mcs; v.len = len; v.fr = fr; v.fpc = fpc;
    v.es = es; v.ed = ed; v.ea = ea; v.ef = ef; v.enp = enp; v.eb = eb;
    vecs.push_back(v);
  endtask

  // Idle inputs with the given expected outputs.
  task automatic idle(input logic [5:0] es, input logic ed, input logic ef,
                      input logic [31:0] enp, input logic eb);
    add(0, 0, 0, 6'd0, 0, 32'h0, es, ed, 1'b0, ef, enp, eb);
  endtask

  task automatic drive_idle();
    rst = 0; stallreq_id = 0; mc_start = 0; mc_len = 0; flush_req = 0; flush_pc = 0;
  endtask

  initial begin
    // reset held 2 cycles with competing requests
    add(1, 0, 1, 6'd3, 1, 32'h55, 6'h00, 0, 0, 0, 32'h0, 0);
    add(1, 1, 1, 6'd3, 1, 32'h55, 6'h00, 0, 0, 0, 32'h0, 0);
    idle(6'h00, 0, 0, 32'h0, 0);
    // load-use, one cycle only
    add(0, 1, 0, 6'd0, 0, 32'h0, 6'b000111, 0, 0, 0, 32'h0, 0);
    idle(6'h00, 0, 0, 32'h0, 0);
    // div length 5, ignored mc_start and overridden stallreq_id while held
    add(0, 0, 1, 6'd5, 0, 32'h0, 6'b001111, 0, 0, 0, 32'h0, 0);
    idle(6'b001111, 0, 0, 32'h0, 1);
    add(0, 0, 1, 6'd2, 0, 32'h0, 6'b001111, 0, 0, 0, 32'h0, 1);
    add(0, 1, 0, 6'd0, 0, 32'h0, 6'b001111, 0, 0, 0, 32'h0, 1);
    idle(6'b001111, 0, 0, 32'h0, 1);
    idle(6'h00, 1, 0, 32'h0, 1);
    idle(6'h00, 0, 0, 32'h0, 0);
    // zero length, also beats load-use
    add(0, 0, 1, 6'd0, 0, 32'h0, 6'h00, 1, 0, 0, 32'h0, 0);
    add(0, 1, 1, 6'd0, 0, 32'h0, 6'h00, 1, 0, 0, 32'h0, 0);
    // length 1
    add(0, 0, 1, 6'd1, 0, 32'h0, 6'b001111, 0, 0, 0, 32'h0, 0);
    idle(6'h00, 1, 0, 32'h0, 1);
    idle(6'h00, 0, 0, 32'h0, 0);
    // length 1, load-use in the release cycle
    add(0, 0, 1, 6'd1, 0, 32'h0, 6'b001111, 0, 0, 0, 32'h0, 0);
    add(0, 1, 0, 6'd0, 0, 32'h0, 6'b000111, 1, 0, 0, 32'h0, 1);
    idle(6'h00, 0, 0, 32'h0, 0);
    // flush aborts a length-8 div
    add(0, 0, 1, 6'd8, 0, 32'h0, 6'b001111, 0, 0, 0, 32'h0, 0);
    idle(6'b001111, 0, 0, 32'h0, 1);
    idle(6'b001111, 0, 0, 32'h0, 1);
    add(0, 1, 0, 6'd0, 1, 32'h140, 6'b111111, 0, 1, 0, 32'h0, 1);
    idle(6'h00, 0, 1, 32'h140, 1);
    idle(6'h00, 0, 0, 32'h0, 0);
    idle(6'h00, 0, 0, 32'h0, 0);
    // flush_req with mc_start in RUN: flush wins, no MCYCLE
    add(0, 1, 1, 6'd3, 1, 32'h200, 6'b111111, 0, 0, 0, 32'h0, 0);
    idle(6'h00, 0, 1, 32'h200, 1);
    idle(6'h00, 0, 0, 32'h0, 0);
    idle(6'h00, 0, 0, 32'h0, 0);
    // back-to-back flush requests
    add(0, 0, 0, 6'd0, 1, 32'h10, 6'b111111, 0, 0, 0, 32'h0, 0);
    add(0, 1, 1, 6'd2, 1, 32'h20, 6'h00, 0, 0, 1, 32'h10, 1);
    idle(6'h00, 0, 1, 32'h20, 1);
    idle(6'h00, 0, 0, 32'h0, 0);
    // reset mid-MCYCLE
    add(0, 0, 1, 6'd5, 0, 32'h0, 6'b001111, 0, 0, 0, 32'h0, 0);
    idle(6'b001111, 0, 0, 32'h0, 1);
    add(1, 0, 0, 6'd0, 0, 32'h0, 6'h00, 0, 0, 0, 32'h0, 0);
    idle(6'h00, 0, 0, 32'h0, 0);
    idle(6'h00, 0, 0, 32'h0, 0);
    // reset mid-FLUSH
    add(0, 0, 0, 6'd0, 1, 32'h44, 6'b111111, 0, 0, 0, 32'h0, 0);
    add(1, 0, 0, 6'd0, 0, 32'h0, 6'h00, 0, 0, 0, 32'h0, 0);
    idle(6'h00, 0, 0, 32'h0, 0);

    drive_idle();
`ifdef STALL_PERF_CNT_EN
    perf_clr = 0;
`endif
    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; stallreq_id = vecs[i].sid; mc_start = vecs[i].mcs;
      mc_len = vecs[i].len; flush_req = vecs[i].fr; flush_pc = vecs[i].fpc;
      #1;
      checks++;
      if (stall !== vecs[i].es || mc_done !== vecs[i].ed || mc_abort !== vecs[i].ea ||
          flush !== vecs[i].ef || new_pc !== vecs[i].enp || busy !== vecs[i].eb) begin
        errors++;
        $display("FAIL vec%0d: got stall=%b done=%b abort=%b flush=%b new_pc=%h busy=%b, want stall=%b done=%b abort=%b flush=%b new_pc=%h busy=%b",
                 i, stall, mc_done, mc_abort, flush, new_pc, busy,
                 vecs[i].es, vecs[i].ed, vecs[i].ea, vecs[i].ef, vecs[i].enp, vecs[i].eb);
      end
    end

`ifdef STALL_PERF_CNT_EN
    @(negedge clk); drive_idle(); perf_clr = 1;
    @(negedge clk); perf_clr = 0; mc_start = 1; mc_len = 6'd5;
    @(negedge clk); drive_idle();
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if (stall_cycles !== 32'd5) begin
      errors++;
      $display("FAIL perf_div: got stall_cycles=%0d want 5", stall_cycles);
    end
    @(negedge clk); perf_clr = 1; stallreq_id = 1;
    @(negedge clk); perf_clr = 0; stallreq_id = 0;
    #1;
    checks++;
    if (stall_cycles !== 32'd0) begin
      errors++;
      $display("FAIL perf_clr: got stall_cycles=%0d want 0", stall_cycles);
    end
`endif

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Pipeline control unit for the 5-stage MIPS core. It sequences stalls and flushes across PC/IF/ID/EX/MEM/WB.
- Arbitrates three requesters:
  - the ID load-use stall request;
  - multi-cycle EX operations (div/madd), whose duration this block counts;
  - exception/redirect flush requests.
- Drives the per-stage stall vector consumed by every pipeline register, plus the flush strobe and redirect PC consumed by pc_reg.

Parameters:
- MC_LEN_W, 6, width of the multi-cycle length field; maximum EX occupancy 2^MC_LEN_W-1 cycles.
- PC_W, 32, redirect PC width (matches `InstAddrBus).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset (`RstEnable = 1'b1).
- stallreq_id  in  1  ID load-use hazard, combinational from id.
- mc_start  in  1  EX begins a multi-cycle op this cycle.
- mc_len  in  MC_LEN_W  cycles EX must be held; valid with mc_start.
- flush_req  in  1  exception/redirect request, one-cycle pulse.
- flush_pc  in  PC_W  redirect target; valid with flush_req.
- stall  out  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = hold stage register.
- mc_done  out  1  multi-cycle result may be written back this cycle.
- mc_abort  out  1  in-flight multi-cycle op cancelled by flush.
- flush  out  1  clear all pipeline registers this cycle.
- new_pc  out  PC_W  PC to load when flush=1.
- busy  out  1  state != RUN.

Behaviour:
- Reset (rst=1 at edge):
  - state=RUN, cnt=0, pend_pc=0.
  - Outputs during reset cycle: stall=6'b000000, mc_done=0, mc_abort=0, flush=0, new_pc=0, busy=0.
- States: RUN, MCYCLE, FLUSH. Encoding is free; busy decodes it.
- stall, mc_done and mc_abort are combinational from state, cnt and the current-cycle inputs (same-cycle response). flush and new_pc are registered, so they depend on state only.
- RUN priority, highest first:
  1. flush_req: stall=6'b111111 this cycle; pend_pc<=flush_pc; next state FLUSH; mc_start ignored.
  2. mc_start with mc_len=0: no stall; mc_done=1 same cycle; stay RUN.
  3. mc_start with mc_len=N≥1: stall=6'b001111; cnt<=N-1; next state MCYCLE.
  4. stallreq_id: stall=6'b000111; stay RUN.
  5. Otherwise: stall=0.
- MCYCLE:
  - flush_req: stall=6'b111111, mc_abort=1, pend_pc<=flush_pc, next state FLUSH; mc_done stays 0.
  - else cnt≠0: stall=6'b001111, cnt<=cnt-1.
  - else (cnt=0): release cycle. mc_done=1, stall=6'b000111 if stallreq_id else 0, next state RUN.
  - mc_start in MCYCLE is ignored; EX is frozen.
- Total EX-held cycles for length N = exactly N. mc_done occurs in cycle N+1 counted from the mc_start cycle.
- FLUSH:
  - flush=1, new_pc=pend_pc, stall=0, next state RUN.
  - flush_req arriving in FLUSH is taken again: pend_pc updated, stay FLUSH one more cycle.
- stallreq_id never overrides an EX hold or flush; a lower stall mask is never asserted in a cycle with a higher one.
- Reset mid-MCYCLE or mid-FLUSH: returns to RUN next edge; no mc_done, mc_abort or flush is emitted for the cancelled operation.
- cnt width = MC_LEN_W; no wrap is possible since the load is N-1 ≤ max.

Optional Feature:
- STALL_PERF_CNT_EN.
- Defined:
  - Adds output stall_cycles[31:0] and input perf_clr[0:0].
  - The counter increments on each cycle with stall[2]=1 (ID held, any cause) and saturates at 32'hFFFFFFFF.
  - perf_clr=1 zeroes it next edge and has priority over increment.
  - Reset value 0.
- Undefined: port and register are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst 2 cycles with mc_start=1, flush_req=1 -> stall=0, flush=0, busy=0 throughout; RUN after release.
- Load-use: stallreq_id=1 for 1 cycle in RUN -> stall=6'b000111 that cycle only, busy=0.
- Div: mc_start=1, mc_len=5 at cycle 10 -> stall=6'b001111 cycles 10-14; cycle 15 mc_done=1, stall=0; busy=1 cycles 11-15.
- Zero/one length:
  - mc_len=0 -> mc_done=1 same cycle, no stall.
  - mc_len=1 -> one stalled cycle, then mc_done.
- Flush aborts div: mc_len=8 at cycle 0, flush_req with flush_pc=32'h0000_0140 at cycle 3 -> cycle 3 stall=6'b111111 and mc_abort=1; cycle 4 flush=1, new_pc=32'h140, stall=0; mc_done never asserted.
- Simultaneous: flush_req and mc_start in the same RUN cycle -> flush path taken, no MCYCLE entry. With STALL_PERF_CNT_EN: after the div test, stall_cycles=5; perf_clr -> 0.
